// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and decode helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Unsigned variants exist only for loads.
  function automatic logic is_legal(input logic is_store, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed bytes of a load and extends them
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [55:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] raw;

  // The top byte of the second word can never fall inside a 4-byte window.
  always_comb begin
    case (off)
      2'd0:    raw = data[31:0];
      2'd1:    raw = data[39:8];
      2'd2:    raw = data[47:16];
      default: raw = data[55:24];
    endcase
    case (size_bytes(funct3))
      3'd1:    result = funct3[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      3'd2:    result = funct3[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-enabled data-memory initiator with split unaligned accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] RESP_ZERO  = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_store_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_load_data,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic [3:0]            mem_write_enable,
  output logic                  store_enable,
  input  logic [31:0]           mem_read_data
);

  lsu_state_t            state;
  logic                  st_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           sdata_q;
  logic [31:0]           lo_buf;
  logic [23:0]           hi_buf;

  logic                  in_idle;
  logic                  s_store;
  logic [2:0]            s_f3;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [31:0]           s_data;
  logic [1:0]            off;
  logic [7:0]            mask;
  logic [63:0]           wdata;
  logic                  crosses;
  logic                  legal;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [31:0]           load_result;

  // In IDLE the lane math runs on the live request so FIRST outputs can be registered at acceptance.
  always_comb begin
    in_idle   = (state == IDLE);
    s_store   = in_idle ? req_is_store   : st_q;
    s_f3      = in_idle ? req_funct3     : f3_q;
    s_addr    = in_idle ? req_address    : addr_q;
    s_data    = in_idle ? req_store_data : sdata_q;
    off       = s_addr[1:0];
    mask      = {4'b0000, size_mask(s_f3)} << off;
    wdata     = {32'b0, s_data} << {off, 3'b000};
    crosses   = ({1'b0, off} + size_bytes(s_f3)) > 3'd4;
    legal     = is_legal(s_store, s_f3);
    word_addr = {s_addr[ADDR_WIDTH-1:2], 2'b00};
  end

  lsu_load_align u_align (
    .data   ({hi_buf, lo_buf}),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .result (load_result)
  );

  assign resp_load_data = (state == RESP && !st_q && !resp_error) ? load_result : RESP_ZERO;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      st_q             <= 1'b0;
      f3_q             <= 3'd0;
      addr_q           <= '0;
      sdata_q          <= 32'd0;
      lo_buf           <= 32'd0;
      hi_buf           <= 24'd0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_error       <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= 32'd0;
      mem_write_enable <= 4'd0;
      store_enable     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            st_q      <= req_is_store;
            f3_q      <= req_funct3;
            addr_q    <= req_address;
            sdata_q   <= req_store_data;
            hi_buf    <= 24'd0;
            req_ready <= 1'b0;
            if (!legal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              state       <= FIRST;
              mem_address <= word_addr;
              if (req_is_store) begin
                store_enable     <= 1'b1;
                mem_write_enable <= mask[3:0];
                mem_write_data   <= wdata[31:0];
              end
            end
          end
        end
        FIRST: begin
          if (!st_q) lo_buf <= mem_read_data;
          if (crosses) begin
            state       <= SECOND;
            mem_address <= mem_address + ADDR_WIDTH'(4);
            if (st_q) begin
              mem_write_enable <= mask[7:4];
              mem_write_data   <= wdata[63:32];
            end
          end else begin
            state            <= RESP;
            resp_valid       <= 1'b1;
            mem_address      <= '0;
            mem_write_data   <= 32'd0;
            mem_write_enable <= 4'd0;
            store_enable     <= 1'b0;
          end
        end
        SECOND: begin
          if (!st_q) hi_buf <= mem_read_data[23:0];
          state            <= RESP;
          resp_valid       <= 1'b1;
          mem_address      <= '0;
          mem_write_data   <= 32'd0;
          mem_write_enable <= 4'd0;
          store_enable     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_store_data = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_load_data;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_enable;
  logic        store_enable;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  int          total = 0;
  int          bad = 0;
  int          se_count = 0;
  int          zero_mask = 0;
  logic [31:0] addr_log [0:8];
  logic [31:0] wd_log [0:8];
  logic [3:0]  we_log [0:8];
  logic        se_log [0:8];

  load_store_unit dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_address      (req_address),
    .req_store_data   (req_store_data),
    .resp_valid       (resp_valid),
    .resp_load_data   (resp_load_data),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .store_enable     (store_enable),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clock) begin
    if (store_enable) begin
      se_count++;
      if (mem_write_enable == 4'd0) zero_mask++;
      for (int i = 0; i < 4; i++)
        if (mem_write_enable[i]) mem[mem_address[7:2]][8*i +: 8] = mem_write_data[8*i +: 8];
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic err);
    for (int i = 0; i < 9; i++) begin
      addr_log[i] = 0; wd_log[i] = 0; we_log[i] = 0; se_log[i] = 0;
    end
    @(negedge clock);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_address = a; req_store_data = d;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'd0; err = 1'b0;
    while (lat < 8) begin
      @(negedge clock);
      lat++;
      addr_log[lat] = mem_address; wd_log[lat] = mem_write_data;
      we_log[lat] = mem_write_enable; se_log[lat] = store_enable;
      if (resp_valid) begin
        rd = resp_load_data; err = resp_error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL rst_resp_error got=%b want=0", resp_error); end
    total++; if (resp_load_data !== 32'd0) begin bad++; $display("FAIL rst_load_data got=%h want=0", resp_load_data); end
    total++; if (mem_address !== 32'd0) begin bad++; $display("FAIL rst_mem_address got=%h want=0", mem_address); end
    total++; if (mem_write_data !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%h want=0", mem_write_data); end
    total++; if (mem_write_enable !== 4'd0) begin bad++; $display("FAIL rst_wen got=%b want=0", mem_write_enable); end
    total++; if (store_enable !== 1'b0) begin bad++; $display("FAIL rst_store_enable got=%b want=0", store_enable); end
  endtask

  task automatic test_sw_aligned();
    int lat; logic [31:0] rd; logic err;
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, lat, rd, err);
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
    total++; if (addr_log[1] !== 32'h10) begin bad++; $display("FAIL sw_addr got=%h want=00000010", addr_log[1]); end
    total++; if (we_log[1] !== 4'b1111) begin bad++; $display("FAIL sw_wen got=%b want=1111", we_log[1]); end
    total++; if (wd_log[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h want=deadbeef", wd_log[1]); end
    total++; if (se_log[1] !== 1'b1) begin bad++; $display("FAIL sw_strobe got=%b want=1", se_log[1]); end
    total++; if (se_log[2] !== 1'b0) begin bad++; $display("FAIL sw_strobe_resp got=%b want=0", se_log[2]); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL sw_error got=%b want=0", err); end
    total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h want=deadbeef", mem[4]); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic err;
    issue(1'b1, 3'd0, 32'h13, 32'h000000A5, lat, rd, err);
    total++; if (we_log[1] !== 4'b1000) begin bad++; $display("FAIL sb_wen got=%b want=1000", we_log[1]); end
    total++; if (wd_log[1] !== 32'hA5000000) begin bad++; $display("FAIL sb_wdata got=%h want=a5000000", wd_log[1]); end
    total++; if (mem[4] !== 32'hA5ADBEEF) begin bad++; $display("FAIL sb_mem got=%h want=a5adbeef", mem[4]); end
    issue(1'b0, 3'd0, 32'h13, 32'd0, lat, rd, err);
    total++; if (rd !== 32'hFFFFFFA5) begin bad++; $display("FAIL lb_data got=%h want=ffffffa5", rd); end
    total++; if (lat !== 2) begin bad++; $display("FAIL lb_latency got=%0d want=2", lat); end
    issue(1'b0, 3'd4, 32'h13, 32'd0, lat, rd, err);
    total++; if (rd !== 32'h000000A5) begin bad++; $display("FAIL lbu_data got=%h want=000000a5", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic err;
    @(negedge clock); mem[4] = 32'h80017F00;
    issue(1'b0, 3'd1, 32'h12, 32'd0, lat, rd, err);
    total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh_hi got=%h want=ffff8001", rd); end
    issue(1'b0, 3'd5, 32'h12, 32'd0, lat, rd, err);
    total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu_hi got=%h want=00008001", rd); end
    issue(1'b0, 3'd1, 32'h10, 32'd0, lat, rd, err);
    total++; if (rd !== 32'h00007F00) begin bad++; $display("FAIL lh_lo got=%h want=00007f00", rd); end
  endtask

  task automatic test_split();
    int lat; logic [31:0] rd; logic err;
    @(negedge clock); mem[3] = 32'd0; mem[4] = 32'd0;
    issue(1'b1, 3'd2, 32'h0E, 32'h11223344, lat, rd, err);
    total++; if (lat !== 3) begin bad++; $display("FAIL split_sw_latency got=%0d want=3", lat); end
    total++; if (addr_log[1] !== 32'h0C) begin bad++; $display("FAIL split_addr1 got=%h want=0000000c", addr_log[1]); end
    total++; if (we_log[1] !== 4'b1100) begin bad++; $display("FAIL split_wen1 got=%b want=1100", we_log[1]); end
    total++; if (wd_log[1] !== 32'h33440000) begin bad++; $display("FAIL split_wdata1 got=%h want=33440000", wd_log[1]); end
    total++; if (addr_log[2] !== 32'h10) begin bad++; $display("FAIL split_addr2 got=%h want=00000010", addr_log[2]); end
    total++; if (we_log[2] !== 4'b0011) begin bad++; $display("FAIL split_wen2 got=%b want=0011", we_log[2]); end
    total++; if (wd_log[2] !== 32'h00001122) begin bad++; $display("FAIL split_wdata2 got=%h want=00001122", wd_log[2]); end
    total++; if (se_log[2] !== 1'b1) begin bad++; $display("FAIL split_strobe2 got=%b want=1", se_log[2]); end
    issue(1'b0, 3'd2, 32'h0E, 32'd0, lat, rd, err);
    total++; if (lat !== 3) begin bad++; $display("FAIL split_lw_latency got=%0d want=3", lat); end
    total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL split_lw_data got=%h want=11223344", rd); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic err;
    @(negedge clock); mem[63] = 32'd0; mem[0] = 32'd0;
    issue(1'b1, 3'd2, 32'hFFFFFFFE, 32'h55667788, lat, rd, err);
    total++; if (addr_log[1] !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_addr1 got=%h want=fffffffc", addr_log[1]); end
    total++; if (addr_log[2] !== 32'h0) begin bad++; $display("FAIL wrap_addr2 got=%h want=00000000", addr_log[2]); end
    total++; if (mem[63] !== 32'h77880000) begin bad++; $display("FAIL wrap_mem_hi got=%h want=77880000", mem[63]); end
    total++; if (mem[0] !== 32'h00005566) begin bad++; $display("FAIL wrap_mem_lo got=%h want=00005566", mem[0]); end
    issue(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0, lat, rd, err);
    total++; if (rd !== 32'h55667788) begin bad++; $display("FAIL wrap_lw got=%h want=55667788", rd); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] rd; logic err; int se_before;
    se_before = se_count;
    issue(1'b0, 3'd3, 32'h10, 32'd0, lat, rd, err);
    total++; if (lat !== 1) begin bad++; $display("FAIL ill_load_latency got=%0d want=1", lat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_load_error got=%b want=1", err); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL ill_load_data got=%h want=0", rd); end
    issue(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, lat, rd, err);
    total++; if (lat !== 1) begin bad++; $display("FAIL ill_store_latency got=%0d want=1", lat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_store_error got=%b want=1", err); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL ill_store_data got=%h want=0", rd); end
    total++; if (se_count !== se_before) begin bad++; $display("FAIL ill_strobes got=%0d want=%0d", se_count, se_before); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err; int rv_seen;
    @(negedge clock); mem[7] = 32'd0; mem[8] = 32'd0;
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
    req_address = 32'h1E; req_store_data = 32'hAABBCCDD;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++; if (mem_address !== 32'h20) begin bad++; $display("FAIL mid_second_addr got=%h want=00000020", mem_address); end
    reset_n = 1'b0;
    #1;
    total++; if (store_enable !== 1'b0) begin bad++; $display("FAIL mid_strobe got=%b want=0", store_enable); end
    total++; if (mem_write_enable !== 4'd0) begin bad++; $display("FAIL mid_wen got=%b want=0", mem_write_enable); end
    total++; if (mem_address !== 32'd0) begin bad++; $display("FAIL mid_addr got=%h want=0", mem_address); end
    total++; if (mem_write_data !== 32'd0) begin bad++; $display("FAIL mid_wdata got=%h want=0", mem_write_data); end
    rv_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (resp_valid) rv_seen++;
    end
    reset_n = 1'b1;
    #1;
    total++; if (rv_seen !== 0) begin bad++; $display("FAIL mid_no_resp got=%0d want=0", rv_seen); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", req_ready); end
    total++; if (mem[7] !== 32'hCCDD0000) begin bad++; $display("FAIL mid_first_word got=%h want=ccdd0000", mem[7]); end
    total++; if (mem[8] !== 32'd0) begin bad++; $display("FAIL mid_second_word got=%h want=0", mem[8]); end
    issue(1'b0, 3'd2, 32'h0C, 32'd0, lat, rd, err);
    total++; if (lat !== 2) begin bad++; $display("FAIL post_lw_latency got=%0d want=2", lat); end
    total++; if (rd !== 32'h33440000) begin bad++; $display("FAIL post_lw_data got=%h want=33440000", rd); end
  endtask

  task automatic test_back_to_back();
    int first; int second; logic ready_in_resp; logic ready_after; logic [31:0] d1;
    first = -1; second = -1; ready_in_resp = 1'b1; ready_after = 1'b0; d1 = 32'd0;
    @(negedge clock); mem[4] = 32'h80017F00;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_address = 32'h10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (first > 0 && c == first + 1) ready_after = req_ready;
      if (resp_valid) begin
        if (first < 0) begin
          first = c; ready_in_resp = req_ready; d1 = resp_load_data;
        end else if (second < 0) begin
          second = c; req_valid = 1'b0;
        end
      end
      if (second > 0) break;
    end
    req_valid = 1'b0;
    total++; if (first !== 2) begin bad++; $display("FAIL b2b_first got=%0d want=2", first); end
    total++; if (second - first !== 3) begin bad++; $display("FAIL b2b_gap got=%0d want=3", second - first); end
    total++; if (ready_in_resp !== 1'b0) begin bad++; $display("FAIL b2b_ready_resp got=%b want=0", ready_in_resp); end
    total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL b2b_ready_after got=%b want=1", ready_after); end
    total++; if (d1 !== 32'h80017F00) begin bad++; $display("FAIL b2b_data got=%h want=80017f00", d1); end
    @(negedge clock);
    total++; if (zero_mask !== 0) begin bad++; $display("FAIL zero_mask_strobes got=%0d want=0", zero_mask); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    test_sw_aligned();
    test_byte();
    test_half();
    test_split();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
